lane_slot_scheduler: RTL and testbench

- Schedules up to NSLOT falling note blocks in one piano lane. Allocates a free slot when the beat chart requests a note, advances every active slot on each movement tick, and retires slots as hit or miss.
- Sits between the beat counter / chart ROM and the VGA renderer. Replaces fixed single-block lane modules with a shared pool of slots.
- Also keeps saturating hit and miss counters for the score display.

---
 rtl/lane_slot_scheduler.sv | 182 ++++++++++++++++++
 tb/tb_lane_slot_scheduler.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lane_slot_scheduler.sv
// Purpose: shared pool of NSLOT falling-note slots for one piano lane (spawn, move, hit/miss retire, score counters).
// Latency: every output is a flop; effects of inputs appear one clk after the sampling edge.
// Backpressure: none; requests that find no free slot are dropped and flagged on sticky overflow.
//
// Ports: clk/rst_n (async active-low), restart (sync clear, top priority), start, stop_or_endgame (freeze),
//        tick (movement strobe), beat_cnt/note_req (chart), key_hit (player press);
//        slot_h/slot_valid (packed slot view for the renderer), hit_pulse/miss_pulse, overflow, hit_cnt/miss_cnt.
module lane_slot_scheduler #(
    parameter int NSLOT    = 4,
    parameter int SPAWN_H  = 120,
    parameter int BOTTOM_H = 720,
    parameter int HIT_LO   = 600,
    parameter int HIT_HI   = 680
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  restart,
    input  logic                  start,
    input  logic                  stop_or_endgame,
    input  logic                  tick,
    input  logic [6:0]            beat_cnt,
    input  logic                  note_req,
    input  logic                  key_hit,
    output logic [NSLOT*10-1:0]   slot_h,
    output logic [NSLOT-1:0]      slot_valid,
    output logic                  hit_pulse,
    output logic                  miss_pulse,
    output logic                  overflow,
    output logic [7:0]            hit_cnt,
    output logic [7:0]            miss_cnt
);

    localparam int         IW       = (NSLOT > 1) ? $clog2(NSLOT) : 1;
    localparam logic [9:0] SPAWN_V  = 10'(SPAWN_H);
    localparam logic [9:0] BOTTOM_V = 10'(BOTTOM_H);
    localparam logic [9:0] HIT_LO_V = 10'(HIT_LO);
    localparam logic [9:0] HIT_HI_V = 10'(HIT_HI);

    typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

    state_t           state_q, state_d;
    logic [6:0]       pre_beat_q;
    logic [9:0]       h_q [NSLOT];
    logic [9:0]       h_d [NSLOT];
    logic [NSLOT-1:0] valid_q, valid_d;
    logic             hit_pulse_q, hit_pulse_d;
    logic             miss_pulse_q, miss_pulse_d;
    logic             overflow_q, overflow_d;
    logic [7:0]       hit_cnt_q, hit_cnt_d;
    logic [7:0]       miss_cnt_q, miss_cnt_d;

    logic             active;
    logic             beat_new;
    logic             spawn_req;
    logic             free_found;
    logic [IW-1:0]    free_idx;
    logic             hit_found;
    logic [IW-1:0]    hit_idx;
    logic [9:0]       best_h;
    logic             miss_any;
    logic [9:0]       h_inc;

    always_comb begin
        state_d      = state_q;
        h_d          = h_q;
        valid_d      = valid_q;
        hit_pulse_d  = 1'b0;
        miss_pulse_d = 1'b0;
        overflow_d   = overflow_q;
        hit_cnt_d    = hit_cnt_q;
        miss_cnt_d   = miss_cnt_q;
        miss_any     = 1'b0;
        h_inc        = '0;

        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (stop_or_endgame) state_d = HOLD;
            HOLD:    if (!stop_or_endgame) state_d = RUN;
            default: state_d = IDLE;
        endcase

        // Freeze applies in the very cycle stop_or_endgame rises, not only once HOLD is reached.
        active    = (state_q == RUN) && !stop_or_endgame;
        beat_new  = beat_cnt > pre_beat_q;
        spawn_req = active && beat_new && note_req;

        // Lowest-index free slot from the registered mask, so a slot being hit this cycle is never reused.
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = NSLOT - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                free_found = 1'b1;
                free_idx   = IW'(i);
            end
        end

        // Tallest in-window slot; strict '>' keeps the lowest index on ties.
        hit_found = 1'b0;
        hit_idx   = '0;
        best_h    = '0;
        for (int i = 0; i < NSLOT; i++) begin
            if (valid_q[i] && (h_q[i] >= HIT_LO_V) && (h_q[i] <= HIT_HI_V) &&
                (!hit_found || (h_q[i] > best_h))) begin
                hit_found = 1'b1;
                hit_idx   = IW'(i);
                best_h    = h_q[i];
            end
        end

        if (active) begin
            for (int i = 0; i < NSLOT; i++) begin
                h_inc = h_q[i] + 10'd1;
                if (key_hit && hit_found && (hit_idx == IW'(i))) begin
                    valid_d[i] = 1'b0;
                    h_d[i]     = BOTTOM_V;
                end else if (spawn_req && free_found && (free_idx == IW'(i))) begin
                    valid_d[i] = 1'b1;
                    h_d[i]     = SPAWN_V;
                end else if (tick && valid_q[i] && (h_q[i] < BOTTOM_V)) begin
                    h_d[i] = h_inc;
                    if (h_inc == BOTTOM_V) begin
                        valid_d[i] = 1'b0;
                        miss_any   = 1'b1;
                    end
                end
            end

            hit_pulse_d  = key_hit && hit_found;
            miss_pulse_d = miss_any;
            if (hit_pulse_d && (hit_cnt_q != 8'hFF)) hit_cnt_d = hit_cnt_q + 8'd1;
            if (miss_any && (miss_cnt_q != 8'hFF))   miss_cnt_d = miss_cnt_q + 8'd1;
            if (spawn_req && !free_found)            overflow_d = 1'b1;
        end

        if (restart) begin
            state_d      = IDLE;
            valid_d      = '0;
            hit_pulse_d  = 1'b0;
            miss_pulse_d = 1'b0;
            overflow_d   = 1'b0;
            hit_cnt_d    = '0;
            miss_cnt_d   = '0;
            for (int i = 0; i < NSLOT; i++) h_d[i] = BOTTOM_V;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            pre_beat_q   <= '0;
            valid_q      <= '0;
            hit_pulse_q  <= 1'b0;
            miss_pulse_q <= 1'b0;
            overflow_q   <= 1'b0;
            hit_cnt_q    <= '0;
            miss_cnt_q   <= '0;
            for (int i = 0; i < NSLOT; i++) h_q[i] <= BOTTOM_V;
        end else begin
            state_q      <= state_d;
            pre_beat_q   <= beat_cnt;
            valid_q      <= valid_d;
            hit_pulse_q  <= hit_pulse_d;
            miss_pulse_q <= miss_pulse_d;
            overflow_q   <= overflow_d;
            hit_cnt_q    <= hit_cnt_d;
            miss_cnt_q   <= miss_cnt_d;
            for (int i = 0; i < NSLOT; i++) h_q[i] <= h_d[i];
        end
    end

    for (genvar g = 0; g < NSLOT; g++) begin : g_pack
        assign slot_h[10*g +: 10] = h_q[g];
    end

    assign slot_valid = valid_q;
    assign hit_pulse  = hit_pulse_q;
    assign miss_pulse = miss_pulse_q;
    assign overflow   = overflow_q;
    assign hit_cnt    = hit_cnt_q;
    assign miss_cnt   = miss_cnt_q;

endmodule

// File: tb/tb_lane_slot_scheduler.sv
// Purpose: directed self-checking bench for lane_slot_scheduler with a pulse-event scoreboard.
// Latency: inputs driven 1 time unit after posedge; outputs checked 1 unit after the following posedge.
// Backpressure: none; the DUT has no flow control.
module tb_lane_slot_scheduler;

    localparam int NSLOT  = 4;
    localparam int EV_HIT  = 1;
    localparam int EV_MISS = 2;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               restart;
    logic               start;
    logic               stop_or_endgame;
    logic               tick;
    logic [6:0]         beat_cnt;
    logic               note_req;
    logic               key_hit;
    logic [NSLOT*10-1:0] slot_h;
    logic [NSLOT-1:0]   slot_valid;
    logic               hit_pulse;
    logic               miss_pulse;
    logic               overflow;
    logic [7:0]         hit_cnt;
    logic [7:0]         miss_cnt;

    int checks   = 0;
    int failures = 0;
    int exp_q[$];
    int beat;

    always #5 clk = ~clk;

    lane_slot_scheduler #(.NSLOT(NSLOT)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .restart         (restart),
        .start           (start),
        .stop_or_endgame (stop_or_endgame),
        .tick            (tick),
        .beat_cnt        (beat_cnt),
        .note_req        (note_req),
        .key_hit         (key_hit),
        .slot_h          (slot_h),
        .slot_valid      (slot_valid),
        .hit_pulse       (hit_pulse),
        .miss_pulse      (miss_pulse),
        .overflow        (overflow),
        .hit_cnt         (hit_cnt),
        .miss_cnt        (miss_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [9:0] h_of(input int i);
        return slot_h[10*i +: 10];
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic spawn();
        beat++;
        beat_cnt = 7'(beat);
        note_req = 1'b1;
        cyc();
        note_req = 1'b0;
    endtask

    task automatic ticks(input int n);
        tick = 1'b1;
        repeat (n) cyc();
        tick = 1'b0;
    endtask

    task automatic press(input logic expect_hit);
        key_hit = 1'b1;
        if (expect_hit) exp_q.push_back(EV_HIT);
        cyc();
        key_hit = 1'b0;
    endtask

    // Scoreboard: every observed pulse cycle must match the next expected event.
    always @(negedge clk) begin
        int k;
        if (rst_n) begin
            if (hit_pulse) begin
                if (exp_q.size() == 0) chk("hit_pulse_unexpected", 32'(hit_pulse), 32'd0);
                else begin
                    k = exp_q.pop_front();
                    chk("hit_pulse_event", k, EV_HIT);
                end
            end
            if (miss_pulse) begin
                if (exp_q.size() == 0) chk("miss_pulse_unexpected", 32'(miss_pulse), 32'd0);
                else begin
                    k = exp_q.pop_front();
                    chk("miss_pulse_event", k, EV_MISS);
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0; restart = 1'b0; start = 1'b0; stop_or_endgame = 1'b0;
        tick = 1'b0; beat_cnt = '0; note_req = 1'b0; key_hit = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset state
        chk("rst_valid", slot_valid, 0);
        for (int i = 0; i < NSLOT; i++) chk("rst_h", h_of(i), 720);
        chk("rst_hit_cnt", hit_cnt, 0);
        chk("rst_miss_cnt", miss_cnt, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_hit_pulse", hit_pulse, 0);
        chk("rst_miss_pulse", miss_pulse, 0);

        // First spawn on beat 8 -> 9, then 5 ticks
        beat_cnt = 7'd8; cyc();
        start = 1'b1; cyc(); start = 1'b0;
        beat = 8;
        spawn();
        chk("spawn1_valid", slot_valid, 4'b0001);
        chk("spawn1_h0", h_of(0), 120);
        ticks(5);
        chk("tick5_h0", h_of(0), 125);

        // Fill all slots, then overflow
        repeat (3) spawn();
        chk("fill_valid", slot_valid, 4'b1111);
        chk("fill_overflow", overflow, 0);
        chk("fill_h3", h_of(3), 120);
        spawn();
        chk("ovf_overflow", overflow, 1);
        chk("ovf_valid", slot_valid, 4'b1111);

        // Clear and run a single slot down to a miss
        restart = 1'b1; cyc(); restart = 1'b0;
        chk("restart1_overflow", overflow, 0);
        chk("restart1_valid", slot_valid, 0);
        start = 1'b1; cyc(); start = 1'b0;
        spawn();
        chk("miss_setup_valid", slot_valid, 4'b0001);
        ticks(599);
        chk("pre_miss_h0", h_of(0), 719);
        chk("pre_miss_valid", slot_valid, 4'b0001);
        exp_q.push_back(EV_MISS);
        ticks(1);
        chk("miss_valid", slot_valid, 0);
        chk("miss_h0", h_of(0), 720);
        chk("miss_cnt1", miss_cnt, 1);
        chk("miss_hit_cnt", hit_cnt, 0);
        cyc();
        chk("miss_pulse_drop", miss_pulse, 0);

        // Two slots at 650 / 610, key_hit coincident with tick
        spawn();
        ticks(40);
        spawn();
        ticks(490);
        chk("hitsel_h0", h_of(0), 650);
        chk("hitsel_h1", h_of(1), 610);
        key_hit = 1'b1; tick = 1'b1; exp_q.push_back(EV_HIT);
        cyc();
        key_hit = 1'b0; tick = 1'b0;
        chk("hitsel_valid", slot_valid, 4'b0010);
        chk("hitsel_h0_retired", h_of(0), 720);
        chk("hitsel_h1_moved", h_of(1), 611);
        chk("hitsel_hit_cnt", hit_cnt, 1);
        press(1'b1);
        chk("hit2_valid", slot_valid, 0);
        chk("hit2_hit_cnt", hit_cnt, 2);

        // Just below the window: no effect; at HIT_LO with a coincident spawn
        spawn();
        ticks(479);
        chk("below_h0", h_of(0), 599);
        press(1'b0);
        chk("below_valid", slot_valid, 4'b0001);
        chk("below_h0_kept", h_of(0), 599);
        chk("below_hit_cnt", hit_cnt, 2);
        ticks(1);
        key_hit = 1'b1; beat++; beat_cnt = 7'(beat); note_req = 1'b1;
        exp_q.push_back(EV_HIT);
        cyc();
        key_hit = 1'b0; note_req = 1'b0;
        chk("hitspawn_valid", slot_valid, 4'b0010);
        chk("hitspawn_h0", h_of(0), 720);
        chk("hitspawn_h1", h_of(1), 120);
        chk("hitspawn_hit_cnt", hit_cnt, 3);

        // Freeze with stop_or_endgame: ticks, beat edge and key_hit ignored
        stop_or_endgame = 1'b1;
        cyc(); cyc();
        beat++; beat_cnt = 7'(beat); note_req = 1'b1; tick = 1'b1;
        cyc();
        note_req = 1'b0;
        repeat (49) cyc();
        tick = 1'b0;
        chk("hold_valid", slot_valid, 4'b0010);
        chk("hold_h1", h_of(1), 120);
        chk("hold_overflow", overflow, 0);
        stop_or_endgame = 1'b0;
        cyc(); cyc();
        ticks(1);
        chk("resume_h1", h_of(1), 121);

        // Tie-break and building up hit_cnt = 7 with three live slots
        repeat (3) spawn();
        chk("tie_fill_valid", slot_valid, 4'b1111);
        ticks(480);
        chk("tie_h0", h_of(0), 600);
        chk("tie_h1", h_of(1), 601);
        chk("tie_h3", h_of(3), 600);
        press(1'b1);
        chk("tallest_valid", slot_valid, 4'b1101);
        chk("tallest_h1", h_of(1), 720);
        press(1'b1);
        chk("tie_low_valid", slot_valid, 4'b1100);
        repeat (2) spawn();
        chk("refill_valid", slot_valid, 4'b1111);
        chk("refill_h0", h_of(0), 120);
        press(1'b1);
        chk("tie2_valid", slot_valid, 4'b1011);
        press(1'b1);
        chk("tie3_valid", slot_valid, 4'b0011);
        spawn();
        chk("three_live_valid", slot_valid, 4'b0111);
        chk("hit_cnt7", hit_cnt, 7);

        // Restart mid-play
        restart = 1'b1; cyc(); restart = 1'b0;
        chk("restart_valid", slot_valid, 0);
        for (int i = 0; i < NSLOT; i++) chk("restart_h", h_of(i), 720);
        chk("restart_hit_cnt", hit_cnt, 0);
        chk("restart_miss_cnt", miss_cnt, 0);
        chk("restart_overflow", overflow, 0);

        // Beat wrap 127 -> 0 is not an edge
        beat_cnt = 7'd127; cyc();
        start = 1'b1; cyc(); start = 1'b0;
        beat_cnt = 7'd0; note_req = 1'b1; cyc(); note_req = 1'b0;
        cyc();
        chk("wrap_valid", slot_valid, 0);
        chk("wrap_overflow", overflow, 0);

        cyc();
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
